// File: rtl/pulse_train_gen.sv
`default_nettype none
// ============================================================================
// Module   : pulse_train_gen
// Brief    : Registered pulse-train generator with latched width/gap/count,
//            abort and single-cycle completion strobe.
// Revision : 1.0
// ============================================================================

module pulse_train_gen #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [CNT_W-1:0] cfg_width,
    input  logic [CNT_W-1:0] cfg_gap,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic             abort,
    output logic             out,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] c_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic [CNT_W-1:0] gap_q,   gap_d;
    logic [CNT_W-1:0] rem_q,   rem_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             out_q,   out_d;
    logic             done_q,  done_d;

    logic             w_accept;
    logic [CNT_W-1:0] w_width_eff;
    logic [CNT_W-1:0] w_gap_eff;

    assign start_ready = (state_q == IDLE) & ~abort;
    assign w_accept    = start_valid & start_ready;
    assign w_width_eff = (cfg_width == '0) ? c_ONE : cfg_width;
    assign w_gap_eff   = (cfg_gap   == '0) ? c_ONE : cfg_gap;

    // cnt_q holds the cycles left in the current phase minus one;
    // rem_q holds the pulses still to come after the current one.
    always_comb begin
        state_d = state_q;
        width_d = width_q;
        gap_d   = gap_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    width_d = w_width_eff;
                    gap_d   = w_gap_eff;
                    if (cfg_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = HIGH;
                        cnt_d   = w_width_eff - c_ONE;
                        rem_d   = cfg_count - c_ONE;
                    end
                end
            end
            HIGH: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - c_ONE;
                end else if (rem_q != '0) begin
                    state_d = LOW;
                    cnt_d   = gap_q - c_ONE;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            LOW: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - c_ONE;
                end else begin
                    state_d = HIGH;
                    cnt_d   = width_q - c_ONE;
                    rem_d   = rem_q - c_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // out is registered from the next state so it lines up with the phase
        out_d = (state_d == HIGH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            width_q <= '0;
            gap_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            width_q <= width_d;
            gap_q   <= gap_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    assign out  = out_q;
    assign done = done_q;
    assign busy = (state_q == HIGH) | (state_q == LOW);

endmodule

`default_nettype wire

// File: tb/tb_pulse_train_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pulse_train_gen
// Brief    : Table-driven cycle vectors plus long-train and abort sequences.
// Revision : 1.0
// ============================================================================

module tb_pulse_train_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_valid;
    logic       start_ready;
    logic [7:0] cfg_width;
    logic [7:0] cfg_gap;
    logic [7:0] cfg_count;
    logic       abort;
    logic       out;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    pulse_train_gen #(.CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .cfg_width   (cfg_width),
        .cfg_gap     (cfg_gap),
        .cfg_count   (cfg_count),
        .abort       (abort),
        .out         (out),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       sv;
        logic [7:0] w;
        logic [7:0] g;
        logic [7:0] c;
        logic       ab;
        logic       e_out;
        logic       e_busy;
        logic       e_done;
        logic       e_ready;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic sv, input int w, input int g, input int c,
                       input logic ab, input logic eo, input logic eb, input logic ed,
                       input logic er);
        vec_t v;
        v.rst = r; v.sv = sv; v.w = 8'(w); v.g = 8'(g); v.c = 8'(c); v.ab = ab;
        v.e_out = eo; v.e_busy = eb; v.e_done = ed; v.e_ready = er;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one train and measures it; abort_after > 0 raises abort for one edge
    // after the sample at that cycle index (index 1 = first cycle after accept).
    task automatic run_train(input int w, input int g, input int c, input int abort_after,
                             input int budget, output int rises, output int highs,
                             output int done_k, output int dones);
        logic prev;
        prev = 1'b0; rises = 0; highs = 0; done_k = 0; dones = 0;
        cfg_width = 8'(w); cfg_gap = 8'(g); cfg_count = 8'(c);
        start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        for (int k = 1; k <= budget; k++) begin
            if (out && !prev) rises++;
            if (out) highs++;
            prev = out;
            if (done) begin
                dones++;
                if (done_k == 0) done_k = k;
            end
            if (abort_after > 0 && k == abort_after + 1) begin
                chk("abort.out", int'(out), 0);
                chk("abort.busy", int'(busy), 0);
                abort = 1'b0;
            end
            if (abort_after > 0 && k == abort_after) abort = 1'b1;
            if (abort_after == 0 && done) break;
            if (abort_after > 0 && k >= abort_after + 6) break;
            step();
        end
    endtask

    initial begin
        int r, h, d, n;
        rst = 1'b1; start_valid = 1'b0; abort = 1'b0;
        cfg_width = '0; cfg_gap = '0; cfg_count = '0;

        // reset, then w=2 g=3 c=3 with cfg changed right after accept
        add(1,0,0,0,0,0, 0,0,0,1);
        add(1,1,2,3,3,0, 0,0,0,1);
        add(0,0,2,3,3,0, 0,0,0,1);
        add(0,1,2,3,3,0, 1,1,0,0);
        add(0,0,7,7,7,0, 1,1,0,0);
        repeat (3) add(0,0,7,7,7,0, 0,1,0,0);
        repeat (2) add(0,0,7,7,7,0, 1,1,0,0);
        repeat (3) add(0,0,7,7,7,0, 0,1,0,0);
        repeat (2) add(0,0,7,7,7,0, 1,1,0,0);
        add(0,0,7,7,7,0, 0,0,1,1);
        add(0,0,7,7,7,0, 0,0,0,1);
        // empty train
        add(0,1,3,0,0,0, 0,0,1,1);
        add(0,0,3,0,0,0, 0,0,0,1);
        // zero width/gap treated as one
        add(0,1,0,0,2,0, 1,1,0,0);
        add(0,0,0,0,2,0, 0,1,0,0);
        add(0,0,0,0,2,0, 1,1,0,0);
        add(0,0,0,0,2,0, 0,0,1,1);
        // abort in IDLE blocks acceptance
        add(0,1,1,1,3,1, 0,0,0,0);
        add(0,0,1,1,3,0, 0,0,0,1);
        // start_valid held: accepted again only from the done cycle
        add(0,1,1,1,2,0, 1,1,0,0);
        add(0,1,3,1,1,0, 0,1,0,0);
        add(0,1,3,1,1,0, 1,1,0,0);
        add(0,1,3,1,1,0, 0,0,1,1);
        add(0,1,3,1,1,0, 1,1,0,0);
        add(0,0,3,1,1,0, 1,1,0,0);
        add(0,0,3,1,1,0, 1,1,0,0);
        add(0,0,3,1,1,0, 0,0,1,1);
        // reset during HIGH
        add(0,1,4,1,2,0, 1,1,0,0);
        add(0,0,4,1,2,0, 1,1,0,0);
        add(1,0,4,1,2,0, 0,0,0,1);
        add(0,0,4,1,2,0, 0,0,0,1);
        add(0,0,4,1,2,0, 0,0,0,1);
        // abort during HIGH
        add(0,1,3,1,2,0, 1,1,0,0);
        add(0,0,3,1,2,1, 0,0,0,0);
        add(0,0,3,1,2,0, 0,0,0,1);

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst; start_valid = tbl[i].sv; abort = tbl[i].ab;
            cfg_width = tbl[i].w; cfg_gap = tbl[i].g; cfg_count = tbl[i].c;
            step();
            chk($sformatf("v%0d.out", i),   int'(out),         int'(tbl[i].e_out));
            chk($sformatf("v%0d.busy", i),  int'(busy),        int'(tbl[i].e_busy));
            chk($sformatf("v%0d.done", i),  int'(done),        int'(tbl[i].e_done));
            chk($sformatf("v%0d.ready", i), int'(start_ready), int'(tbl[i].e_ready));
        end
        rst = 1'b0; start_valid = 1'b0; abort = 1'b0;

        run_train(2, 3, 3, 0, 100, r, h, d, n);
        chk("w2g3c3.rises", r, 3);
        chk("w2g3c3.highs", h, 6);
        chk("w2g3c3.done_at", d, 13);
        chk("w2g3c3.dones", n, 1);
        step();

        run_train(1, 1, 255, 0, 2000, r, h, d, n);
        chk("maxcount.rises", r, 255);
        chk("maxcount.highs", h, 255);
        chk("maxcount.done_at", d, 255 + 254 + 1);
        step();

        run_train(255, 255, 2, 0, 2000, r, h, d, n);
        chk("maxwg.rises", r, 2);
        chk("maxwg.highs", h, 510);
        chk("maxwg.done_at", d, 510 + 255 + 1);
        step();

        run_train(1, 2, 5, 5, 100, r, h, d, n);
        chk("abort.rises", r, 2);
        chk("abort.highs", h, 2);
        chk("abort.dones", n, 0);
        chk("abort.ready_after", int'(start_ready), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/pulse_train_gen.md
PULSE_TRAIN_GEN -- requirements
Module: pulse_train_gen

Interface
REQ-001: Parameter CNT_W, default 8, width of the pulse width, gap and count fields.
REQ-002: clk  input  1  sole clock; all state updates on posedge clk.
REQ-003: rst  input  1  synchronous, active-high reset.
REQ-004: start_valid  input  1  request to start a pulse train.
REQ-005: start_ready  output  1  request can be accepted this cycle.
REQ-006: cfg_width  input  CNT_W  high-phase length in cycles per pulse; 0 treated as 1.
REQ-007: cfg_gap  input  CNT_W  low-phase length in cycles between pulses; 0 treated as 1.
REQ-008: cfg_count  input  CNT_W  number of pulses in the train; 0 = empty train.
REQ-009: abort  input  1  terminate the active train.
REQ-010: out  output  1  registered pulse-train waveform, consumed by a downstream rising-edge detector.
REQ-011: busy  output  1  train in progress (state HIGH or LOW).
REQ-012: done  output  1  single-cycle pulse on normal train completion.

Function
REQ-013: States SHALL be IDLE, HIGH, LOW; all outputs SHALL be driven from registers or from state only.
REQ-014: start_ready SHALL equal (state == IDLE) & ~abort.
REQ-015: Accept SHALL be start_valid & start_ready at a posedge; cfg_width, cfg_gap and cfg_count SHALL be latched on accept, and later cfg changes SHALL have no effect on the active train.
REQ-016: On accept with cfg_count != 0, the block SHALL enter HIGH next cycle; out SHALL be 1 from cycle T+1 when accept is at cycle T.
REQ-017: HIGH SHALL last exactly max(cfg_width,1) cycles with out = 1.
REQ-018: After HIGH, if pulses remaining > 0, the block SHALL enter LOW for exactly max(cfg_gap,1) cycles with out = 0, then return to HIGH.
REQ-019: After the HIGH phase of the last pulse, the block SHALL enter IDLE with out = 0 (no trailing gap); done SHALL be 1 in that first IDLE cycle.
REQ-020: On accept with cfg_count == 0, state SHALL remain IDLE, out SHALL stay 0, and done SHALL be 1 in cycle T+1.
REQ-021: Number of 0->1 transitions on out per completed train SHALL equal cfg_count; the maximum count (2^CNT_W-1) and maximum width/gap SHALL be supported without wrap-around.
REQ-022: A new start SHALL be acceptable in the same cycle that done is 1; a back-to-back train then shows exactly one low cycle between trains.
REQ-023: abort while busy SHALL force IDLE and out = 0 in the next cycle, with done staying 0; abort in IDLE SHALL only block acceptance (REQ-014).
REQ-024: busy SHALL be 1 exactly in HIGH and LOW.
REQ-025: start_valid while not ready SHALL be ignored with no queuing.

Reset
REQ-026: While rst = 1 at a posedge, the next state SHALL be IDLE, with out = 0, done = 0, busy = 0, and all counters and latched cfg cleared.
REQ-027: rst SHALL take priority over start_valid and abort; reset mid-train SHALL drop out to 0 in the next cycle without asserting done.
REQ-028: start_ready SHALL be 1 in the first cycle after rst deasserts, provided abort = 0.

Verification
REQ-029: width=2, gap=3, count=3, accept at T -> out high in T+1..T+2, T+6..T+7 and T+11..T+12; done at T+13; 3 rising edges counted by an edge detector.
REQ-030: width=0, gap=0, count=2 -> out pattern 1,0,1 then IDLE; done 1 in the cycle after the second high.
REQ-031: count=0 -> out stays 0, busy stays 0, done = 1 at T+1.
REQ-032: count=5 with abort asserted during the 2nd LOW phase -> out = 0 and busy = 0 in the next cycle; done never 1; 2 rising edges total.
REQ-033: Second start_valid held high during a train -> not accepted until the done cycle; next train's first high occurs exactly one cycle after done; cfg changes mid-train do not alter the waveform.
REQ-034: rst pulsed during HIGH -> out = 0, busy = 0, done = 0 next cycle; start_ready = 1 once rst is released.
